prs_game_fsm: RTL and testbench
===============================

Name: prs_game_fsm

Overview:
Game-control stage directly downstream of the PS/2 mouse decoder. Consumes its CLK-domain `selection` (scroll) and `click` (right click) levels and runs rock-paper-scissors rounds against a pseudo-random CPU pick. Keeps the score. Drives the 4-bit `text` code and `enable` consumed by the text display.

Parameters:
SHOW_CYCLES, 50_000_000, CLK cycles each of REVEAL and RESULT is held (≥2)
TARGET_SCORE, 5, score (1..9) at which the game ends

Ports:
CLK  input  1  system clock, all logic on posedge
RESET  input  1  asynchronous, active-low reset
enable  input  1  game enable (switch); low forces IDLE
selection  input  1  scroll-wheel level from mouse decoder; rising edge = next choice
click  input  1  right-click level from mouse decoder; rising edge = confirm
text  output  4  display code to text display
display_enable  output  1  registered copy of enable
player_choice  output  2  0 rock, 1 paper, 2 scissors
cpu_choice  output  2  same encoding
result  output  2  0 none, 1 win, 2 lose, 3 tie
score_player  output  4  0..9
score_cpu  output  4  0..9
round_done  output  1  one-cycle pulse when a round result is scored

Behaviour:
- Reset (RESET=0, async): state IDLE; text=BLANK(0); choices 0; result 0; scores 0; round_done 0; display_enable 0; edge registers 0; cpu counter 0.
- Edge detect: sel_rise = selection & ~selection_q; clk_rise = click & ~click_q. The _q registers update every cycle in all states, so edges arriving in a state that ignores them are discarded, not queued.
- cpu counter: free-running mod-3 (0,1,2,0…); increments every cycle after reset, independent of state and enable.
- All outputs are registered. text reflects the current state/choice one cycle after the causing edge.
- IDLE: text=READY(7).
  - enable=1 → SELECT; player_choice=0; text=ROCK(1).
- SELECT: text=player_choice+1.
  - sel_rise → player_choice advances 0→1→2→0.
  - clk_rise → cpu_choice latches the cpu counter value of that cycle; timer loads SHOW_CYCLES-1; go to REVEAL.
  - sel_rise and clk_rise in the same cycle: click wins and the choice is not advanced.
- REVEAL: text=cpu_choice+1. Timer decrements each cycle; at 0 → RESULT.
  - On the transition, result and scores are computed:
    - player==cpu → tie (3), no increment.
    - player==(cpu+1) mod 3 → win (1), score_player+1.
    - otherwise → lose (2), score_cpu+1.
  - Scores saturate at 9. round_done=1 for exactly that cycle. Timer reloads SHOW_CYCLES-1.
- RESULT: text=WIN(4)/LOSE(5)/TIE(6) per result. At timer 0:
  - either score ≥ TARGET_SCORE → OVER.
  - otherwise → SELECT, keeping player_choice; result cleared to 0.
- OVER: text=OVER(8).
  - clk_rise → scores and result cleared; go to SELECT with player_choice=0.
  - sel_rise ignored.
- enable=0 in any state → IDLE next cycle. Timer and result are cleared; scores are retained. enable returning to 1 restarts at SELECT.
- RESET asserted mid-round aborts immediately to reset values.
- Codes 9..15 are never driven.

Decomposition:
- Shared package/include prs_pkg: text codes (BLANK 0, ROCK 1, PAPER 2, SCISSORS 3, WIN 4, LOSE 5, TIE 6, READY 7, OVER 8), choice encodings, result encodings, state encodings (IDLE, SELECT, REVEAL, RESULT, OVER).
- One natural sub-module, prs_judge: combinational winner function (player, cpu → result).
- Edge detectors, cpu counter, timer and FSM stay in prs_game_fsm.

Test Plan:
- Settings: SHOW_CYCLES=4, TARGET_SCORE=2.
- Reset release, enable=1 → text goes 7 then 1 on the next cycle; display_enable=1.
- In SELECT, three selection pulses → text 2, 3, 1; player_choice 1, 2, 0.
- Player paper (1); click rise when cpu counter=0 → REVEAL text=1 for 4 cycles, then text=4, result=1, score_player=1, round_done pulses once. Text returns to 2 after 4 more cycles.
- Same-cycle selection and click rise in SELECT → choice unchanged, enters REVEAL.
- Two CPU wins (player rock vs cpu paper) → score_cpu=2, text=5 then 8 (OVER). Selection is ignored there; click → scores 0, text=1.
- enable dropped during REVEAL → IDLE (text 7) next cycle, scores kept. RESET pulse mid-RESULT → all outputs at reset values immediately.

Source files
------------

// File: rtl/prs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prs_pkg
// Description : Shared encodings for the rock-paper-scissors game controller:
//               display text codes, choice and result encodings, FSM states,
//               and small helpers that map choices/results to text codes.
// Revision    : 1.0 - initial release
// ============================================================================
package prs_pkg;

    // Text display codes (9..15 are never driven)
    localparam logic [3:0] c_txt_blank    = 4'd0;
    localparam logic [3:0] c_txt_rock     = 4'd1;
    localparam logic [3:0] c_txt_paper    = 4'd2;
    localparam logic [3:0] c_txt_scissors = 4'd3;
    localparam logic [3:0] c_txt_win      = 4'd4;
    localparam logic [3:0] c_txt_lose     = 4'd5;
    localparam logic [3:0] c_txt_tie      = 4'd6;
    localparam logic [3:0] c_txt_ready    = 4'd7;
    localparam logic [3:0] c_txt_over     = 4'd8;

    // Choice encodings
    localparam logic [1:0] c_rock     = 2'd0;
    localparam logic [1:0] c_paper    = 2'd1;
    localparam logic [1:0] c_scissors = 2'd2;

    // Result encodings
    localparam logic [1:0] c_res_none = 2'd0;
    localparam logic [1:0] c_res_win  = 2'd1;
    localparam logic [1:0] c_res_lose = 2'd2;
    localparam logic [1:0] c_res_tie  = 2'd3;

    // Game FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_REVEAL = 3'd2,
        ST_RESULT = 3'd3,
        ST_OVER   = 3'd4
    } state_t;

    // Next choice in the scroll order rock -> paper -> scissors -> rock
    function automatic logic [1:0] next_choice(input logic [1:0] c);
        return (c == c_scissors) ? c_rock : c + 2'd1;
    endfunction

    // Choice codes map directly onto ROCK/PAPER/SCISSORS text codes
    function automatic logic [3:0] choice_text(input logic [1:0] c);
        return {2'b00, c} + 4'd1;
    endfunction

    function automatic logic [3:0] result_text(input logic [1:0] r);
        logic [3:0] t;
        case (r)
            c_res_win:  t = c_txt_win;
            c_res_lose: t = c_txt_lose;
            c_res_tie:  t = c_txt_tie;
            default:    t = c_txt_blank;
        endcase
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prs_game_fsm_judge.sv
`default_nettype none
// ============================================================================
// Module      : prs_judge
// Description : Combinational round judge.
//   player [1:0] : player's choice
//   cpu    [1:0] : CPU's choice
//   result [1:0] : tie when equal, win when player beats cpu, else lose
// Revision    : 1.0 - initial release
// ============================================================================
module prs_judge
    import prs_pkg::*;
(
    input  logic [1:0] player,
    input  logic [1:0] cpu,
    output logic [1:0] result
);

    logic [1:0] w_beats_cpu;

    // The choice that beats cpu is the next one in scroll order
    assign w_beats_cpu = next_choice(cpu);

    always_comb begin
        result = c_res_lose;
        if (player == cpu) begin
            result = c_res_tie;
        end else if (player == w_beats_cpu) begin
            result = c_res_win;
        end
    end

endmodule
`default_nettype wire

// File: rtl/prs_game_fsm.sv
`default_nettype none
// ============================================================================
// Module      : prs_game_fsm
// Description : Rock-paper-scissors game controller fed by the mouse decoder.
//   CLK            : system clock, posedge
//   RESET          : asynchronous active-low reset
//   enable         : game enable; low returns to IDLE
//   selection      : scroll level, rising edge advances player choice
//   click          : right-click level, rising edge confirms / restarts
//   text [3:0]     : display code for the text display
//   display_enable : registered copy of enable
//   player_choice, cpu_choice [1:0] : 0 rock, 1 paper, 2 scissors
//   result [1:0]   : 0 none, 1 win, 2 lose, 3 tie
//   score_player, score_cpu [3:0] : saturating scores 0..9
//   round_done     : one-cycle pulse when a round is scored
// Revision    : 1.0 - initial release
// ============================================================================
module prs_game_fsm
    import prs_pkg::*;
#(
    parameter int SHOW_CYCLES  = 50_000_000,
    parameter int TARGET_SCORE = 5
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       enable,
    input  logic       selection,
    input  logic       click,
    output logic [3:0] text,
    output logic       display_enable,
    output logic [1:0] player_choice,
    output logic [1:0] cpu_choice,
    output logic [1:0] result,
    output logic [3:0] score_player,
    output logic [3:0] score_cpu,
    output logic       round_done
);

    localparam int         c_tw         = (SHOW_CYCLES > 2) ? $clog2(SHOW_CYCLES) : 1;
    localparam logic [c_tw-1:0] c_timer_load = c_tw'(SHOW_CYCLES - 1);
    localparam logic [3:0] c_target     = 4'(TARGET_SCORE);
    localparam logic [3:0] c_score_max  = 4'd9;

    state_t          r_state;
    logic            r_sel_q;
    logic            r_clk_q;
    logic [1:0]      r_cnt;
    logic [c_tw-1:0] r_timer;

    logic            w_sel_rise;
    logic            w_clk_rise;
    logic [1:0]      w_next_choice;
    logic [1:0]      w_judge;

    assign w_sel_rise    = selection & ~r_sel_q;
    assign w_clk_rise    = click & ~r_clk_q;
    assign w_next_choice = next_choice(player_choice);

    prs_judge u_judge (
        .player (player_choice),
        .cpu    (cpu_choice),
        .result (w_judge)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state        <= ST_IDLE;
            r_sel_q        <= 1'b0;
            r_clk_q        <= 1'b0;
            r_cnt          <= 2'd0;
            r_timer        <= '0;
            text           <= c_txt_blank;
            display_enable <= 1'b0;
            player_choice  <= c_rock;
            cpu_choice     <= c_rock;
            result         <= c_res_none;
            score_player   <= 4'd0;
            score_cpu      <= 4'd0;
            round_done     <= 1'b0;
        end else begin
            // Edge history tracks the inputs every cycle, so edges seen in a
            // state that ignores them are dropped rather than queued.
            r_sel_q        <= selection;
            r_clk_q        <= click;
            r_cnt          <= (r_cnt == 2'd2) ? 2'd0 : r_cnt + 2'd1;
            display_enable <= enable;
            round_done     <= 1'b0;

            if (!enable) begin
                // Scores survive a disable; the round in progress does not.
                r_state <= ST_IDLE;
                r_timer <= '0;
                result  <= c_res_none;
                text    <= c_txt_ready;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state       <= ST_SELECT;
                        player_choice <= c_rock;
                        text          <= c_txt_rock;
                    end

                    ST_SELECT: begin
                        // Click has priority over a simultaneous scroll
                        if (w_clk_rise) begin
                            cpu_choice <= r_cnt;
                            r_timer    <= c_timer_load;
                            r_state    <= ST_REVEAL;
                            text       <= choice_text(r_cnt);
                        end else if (w_sel_rise) begin
                            player_choice <= w_next_choice;
                            text          <= choice_text(w_next_choice);
                        end
                    end

                    ST_REVEAL: begin
                        if (r_timer == '0) begin
                            result     <= w_judge;
                            text       <= result_text(w_judge);
                            round_done <= 1'b1;
                            r_timer    <= c_timer_load;
                            r_state    <= ST_RESULT;
                            if (w_judge == c_res_win && score_player != c_score_max) begin
                                score_player <= score_player + 4'd1;
                            end
                            if (w_judge == c_res_lose && score_cpu != c_score_max) begin
                                score_cpu <= score_cpu + 4'd1;
                            end
                        end else begin
                            r_timer <= r_timer - 1'b1;
                        end
                    end

                    ST_RESULT: begin
                        if (r_timer == '0) begin
                            if (score_player >= c_target || score_cpu >= c_target) begin
                                r_state <= ST_OVER;
                                text    <= c_txt_over;
                            end else begin
                                r_state <= ST_SELECT;
                                result  <= c_res_none;
                                text    <= choice_text(player_choice);
                            end
                        end else begin
                            r_timer <= r_timer - 1'b1;
                        end
                    end

                    ST_OVER: begin
                        if (w_clk_rise) begin
                            score_player  <= 4'd0;
                            score_cpu     <= 4'd0;
                            result        <= c_res_none;
                            player_choice <= c_rock;
                            r_state       <= ST_SELECT;
                            text          <= c_txt_rock;
                        end
                    end

                    default: begin
                        r_state <= ST_IDLE;
                        text    <= c_txt_ready;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prs_game_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_prs_game_fsm
// Description : Self-checking bench for prs_game_fsm with SHOW_CYCLES=4 and
//               TARGET_SCORE=2: a per-cycle vector table for the enable and
//               scroll behaviour, then hand-written round sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prs_game_fsm;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       enable = 1'b0;
    logic       selection = 1'b0;
    logic       click = 1'b0;
    logic [3:0] text;
    logic       display_enable;
    logic [1:0] player_choice;
    logic [1:0] cpu_choice;
    logic [1:0] result;
    logic [3:0] score_player;
    logic [3:0] score_cpu;
    logic       round_done;

    int total = 0;
    int bad   = 0;

    // Reference mod-3 counter, reset alongside the DUT
    logic [1:0] r_tb_cnt;

    always #5 CLK = ~CLK;

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) r_tb_cnt <= 2'd0;
        else        r_tb_cnt <= (r_tb_cnt == 2'd2) ? 2'd0 : r_tb_cnt + 2'd1;
    end

    prs_game_fsm #(
        .SHOW_CYCLES  (4),
        .TARGET_SCORE (2)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .enable         (enable),
        .selection      (selection),
        .click          (click),
        .text           (text),
        .display_enable (display_enable),
        .player_choice  (player_choice),
        .cpu_choice     (cpu_choice),
        .result         (result),
        .score_player   (score_player),
        .score_cpu      (score_cpu),
        .round_done     (round_done)
    );

    typedef struct {
        logic       en;
        logic       sel;
        logic       clk;
        logic [3:0] exp_text;
        logic [1:0] exp_pc;
        logic       exp_de;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive inputs at the falling edge, sample 1 time unit after the rising edge
    task automatic step(input logic en, input logic sel, input logic clk);
        @(negedge CLK);
        enable = en; selection = sel; click = clk;
        @(posedge CLK);
        #1;
    endtask

    // Stop at a falling edge where the DUT counter equals want
    task automatic align(input logic [1:0] want);
        int n;
        n = 0;
        @(negedge CLK);
        enable = 1'b1; selection = 1'b0; click = 1'b0;
        while (r_tb_cnt != want && n < 8) begin
            @(negedge CLK);
            n++;
        end
        chk("align_bound", (n < 8) ? 1 : 0, 1);
    endtask

    // One full round from the click in SELECT to the state after RESULT
    task automatic play(input logic with_sel, input logic [1:0] want,
                        input logic [1:0] exp_pc, input logic [1:0] exp_res,
                        input int exp_sp, input int exp_sc, input int exp_end);
        int res_text;
        res_text = (exp_res == 2'd1) ? 4 : (exp_res == 2'd2) ? 5 : 6;
        align(want);
        selection = with_sel; click = 1'b1;
        @(posedge CLK);
        #1;
        chk("reveal_text", text, int'(want) + 1);
        chk("reveal_pc", player_choice, exp_pc);
        chk("reveal_cpu", cpu_choice, want);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0);
            chk("reveal_hold", text, int'(want) + 1);
            chk("reveal_rd", round_done, 0);
        end
        step(1'b1, 1'b0, 1'b0);
        chk("result_text", text, res_text);
        chk("result_code", result, exp_res);
        chk("round_done", round_done, 1);
        chk("score_player", score_player, exp_sp);
        chk("score_cpu", score_cpu, exp_sc);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0);
            chk("result_hold", text, res_text);
            chk("result_rd", round_done, 0);
        end
        step(1'b1, 1'b0, 1'b0);
        chk("end_text", text, exp_end);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_text"}, text, 0);
        chk({tag, "_de"}, display_enable, 0);
        chk({tag, "_pc"}, player_choice, 0);
        chk({tag, "_cpu"}, cpu_choice, 0);
        chk({tag, "_res"}, result, 0);
        chk({tag, "_sp"}, score_player, 0);
        chk({tag, "_sc"}, score_cpu, 0);
        chk({tag, "_rd"}, round_done, 0);
    endtask

    initial begin
        //          en   sel  clk  text pc   de
        vecs[0] = '{1'b0, 1'b0, 1'b0, 4'd7, 2'd0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 4'd1, 2'd0, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 4'd2, 2'd1, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 4'd2, 2'd1, 1'b1}; // held level, no edge
        vecs[4] = '{1'b1, 1'b0, 1'b0, 4'd2, 2'd1, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 4'd3, 2'd2, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 4'd3, 2'd2, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 4'd1, 2'd0, 1'b1};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 4'd1, 2'd0, 1'b1};
        vecs[9] = '{1'b1, 1'b1, 1'b0, 4'd2, 2'd1, 1'b1};

        #12;
        chk_reset("reset");
        @(negedge CLK);
        RESET = 1'b1;

        for (int i = 0; i < 10; i++) begin
            step(vecs[i].en, vecs[i].sel, vecs[i].clk);
            chk($sformatf("vec%0d_text", i), text, vecs[i].exp_text);
            chk($sformatf("vec%0d_pc", i), player_choice, vecs[i].exp_pc);
            chk($sformatf("vec%0d_de", i), display_enable, vecs[i].exp_de);
        end

        // Paper vs rock: player wins
        play(1'b0, 2'd0, 2'd1, 2'd1, 1, 0, 2);
        // Scroll and click together: click wins, paper vs paper ties
        play(1'b1, 2'd1, 2'd1, 2'd3, 1, 0, 2);
        chk("result_cleared", result, 0);

        // Scroll paper -> scissors -> rock
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("scroll_rock_pc", player_choice, 0);
        chk("scroll_rock_text", text, 1);

        // Rock vs paper twice: CPU reaches target, game over
        play(1'b0, 2'd1, 2'd0, 2'd2, 1, 1, 1);
        play(1'b0, 2'd1, 2'd0, 2'd2, 1, 2, 8);

        step(1'b1, 1'b1, 1'b0);
        chk("over_sel_text", text, 8);
        chk("over_sel_pc", player_choice, 0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        chk("restart_text", text, 1);
        chk("restart_sp", score_player, 0);
        chk("restart_sc", score_cpu, 0);
        chk("restart_res", result, 0);

        // Rock vs scissors: player wins
        play(1'b0, 2'd2, 2'd0, 2'd1, 1, 0, 1);

        // Disable during REVEAL
        align(2'd0);
        click = 1'b1;
        @(posedge CLK);
        #1;
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("dis_text", text, 7);
        chk("dis_de", display_enable, 0);
        chk("dis_sp", score_player, 1);
        chk("dis_res", result, 0);
        step(1'b1, 1'b0, 1'b0);
        chk("reen_text", text, 1);
        chk("reen_pc", player_choice, 0);

        // Reset in the middle of RESULT
        align(2'd1);
        click = 1'b1;
        @(posedge CLK);
        #1;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
        chk("pre_reset_text", text, 5);
        #2;
        RESET = 1'b0;
        #1;
        chk_reset("midreset");
        @(negedge CLK);
        RESET = 1'b1;
        step(1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
